pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 32 (`INSTR_WIDTH`), width of one pipeline payload (e.g. {instr} or {pc}).
REQ-002 Parameter NUM_CH, default 2, number of independent payload channels carried per beat (e.g. instr, pc).
REQ-003 Parameter BUBBLE, default 0, DATA_W-bit value driven on every channel of out_data when out_valid=0.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  discard all held beats (branch/exception redirect).
REQ-007 in_valid  input  1  upstream beat present.
REQ-008 in_ready  output  1  stage can accept a beat this cycle; registered, no combinational path from out_ready.
REQ-009 in_data  input  NUM_CH*DATA_W  upstream payload, channel k at bits [k*DATA_W +: DATA_W].
REQ-010 out_valid  output  1  downstream beat present.
REQ-011 out_ready  input  1  downstream accepts beat (deasserted = stall).
REQ-012 out_data  output  NUM_CH*DATA_W  downstream payload, same packing as in_data.
REQ-013 occupancy  output  2  number of held beats, 0..2.

Function
REQ-014 Storage SHALL be two entries: MAIN (drives out_data) and SKID (overflow); states EMPTY (0 held), FULL (MAIN only), SKID (both held).
REQ-015 A beat SHALL transfer upstream when in_valid & in_ready, downstream when out_valid & out_ready, both sampled at the clock edge.
REQ-016 in_ready SHALL equal (state != SKID), taken from the registered state.
REQ-017 out_valid SHALL equal (state != EMPTY); out_data SHALL equal MAIN when valid, BUBBLE replicated NUM_CH times otherwise.
REQ-018 EMPTY: push -> FULL, data to MAIN; no push -> EMPTY.
REQ-019 FULL: push & pop -> FULL, MAIN <= in_data; push only -> SKID, SKID <= in_data; pop only -> EMPTY; neither -> FULL, MAIN held.
REQ-020 SKID: pop -> FULL, MAIN <= SKID; no pop -> SKID, both held; no push is possible (in_ready=0).
REQ-021 Latency SHALL be one cycle: a beat pushed into EMPTY at edge N is presented with out_valid=1 after edge N.
REQ-022 Sustained throughput SHALL be one beat per cycle when out_ready=1 continuously.
REQ-023 Beats SHALL leave in push order; no beat duplicated or dropped except by flush or rst.
REQ-024 flush=1 at an edge SHALL force state EMPTY; any beat pushed in that cycle SHALL be discarded; a pop in that cycle is still counted as consumed by downstream.
REQ-025 flush and rst asserted together SHALL behave as rst.
REQ-026 occupancy SHALL be 0/1/2 for EMPTY/FULL/SKID.
REQ-027 Data registers MAY hold stale contents when not valid; only out_data masking (REQ-017) is observable.

Reset
REQ-028 On rst=1 at an edge: state EMPTY, out_valid=0, in_ready=1, occupancy=0, out_data=BUBBLE on all channels.
REQ-029 rst mid-transfer SHALL discard MAIN and SKID contents; no beat pushed in the reset cycle is retained.
REQ-030 Reset SHALL take effect only on a clock edge (synchronous); no asynchronous path.

Structure
REQ-031 State encoding (EMPTY/FULL/SKID) and the default DATA_W (`INSTR_WIDTH`) SHALL live in the shared defines file.
REQ-032 One sub-module, FlopEnRC, SHALL be instantiated per entry (MAIN, SKID) with width NUM_CH*DATA_W; control FSM stays in pipe_skid_reg.
REQ-033 pipe_skid_reg SHALL be usable as a drop-in IF/ID, ID/EX, EX/MEM or MEM/WB stage by choice of NUM_CH.

Verification
REQ-034 rst, then in_valid=1 data {0x00400000,0x20080005}, out_ready=1 -> next cycle out_valid=1, out_data matches, occupancy=1.
REQ-035 Stream 8 beats 1..8 with out_ready=1 -> beats 1..8 out in order on consecutive cycles, in_ready never drops.
REQ-036 FULL, out_ready=0, push beat B -> occupancy=2, in_ready=0; raise out_ready -> A then B emitted, in_ready=1 after first pop.
REQ-037 SKID state, flush=1 with in_valid=1 -> next cycle out_valid=0, out_data=BUBBLE, occupancy=0, pushed beat never appears.
REQ-038 Random in_valid/out_ready (50%) for 10000 cycles vs scoreboard -> no loss, no duplication, order preserved.
REQ-039 rst asserted while SKID and flush=1 -> state matches REQ-028 next cycle.

Source files
------------

// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the skid-buffered pipeline stage: default payload
// width and the control state encoding.
package pipe_skid_reg_pkg;

  localparam int INSTR_WIDTH = 32;

  // Encoding equals the number of held beats, so occupancy is the state value.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_skid_reg_flopenrc.sv
// Enabled register with synchronous clear, used for each payload entry.
module FlopEnRC #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              en,
  input  logic              clr,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // Clear wins over load; otherwise hold.
  always_ff @(posedge clk) begin
    if (clr)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffered pipeline register. MAIN drives the output, SKID
// catches the beat accepted while downstream stalls, so in_ready comes
// straight from registered state with no path from out_ready.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int                DATA_W = INSTR_WIDTH,
  parameter int                NUM_CH = 2,
  parameter logic [DATA_W-1:0] BUBBLE = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [1:0]               occupancy
);

  localparam int W = NUM_CH * DATA_W;

  state_t         state_p0;
  state_t         state_d;
  logic           vld_p0;
  logic           push;
  logic           pop;
  logic           main_en;
  logic           skid_en;
  logic [W-1:0]   main_d;
  logic [W-1:0]   main_p0;
  logic [W-1:0]   skid_p0;

  assign vld_p0 = (state_p0 != ST_EMPTY);
  assign push   = in_valid & in_ready;
  assign pop    = vld_p0 & out_ready;

  // State register: only control is reset; flush is folded into state_d.
  always_ff @(posedge clk) begin
    if (rst)
      state_p0 <= ST_EMPTY;
    else
      state_p0 <= state_d;
  end

  // Next-state and entry load decisions.
  always_comb begin
    state_d = state_p0;
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = in_data;
    case (state_p0)
      ST_EMPTY: begin
        if (push) begin
          state_d = ST_FULL;
          main_en = 1'b1;
        end
      end
      ST_FULL: begin
        if (push && pop) begin
          main_en = 1'b1;
        end else if (push) begin
          state_d = ST_SKID;
          skid_en = 1'b1;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (pop) begin
          state_d = ST_FULL;
          main_en = 1'b1;
          main_d  = skid_p0;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // A redirect drops everything held and anything arriving this cycle.
    if (flush) begin
      state_d = ST_EMPTY;
      main_en = 1'b0;
      skid_en = 1'b0;
    end
  end

  // Handshake outputs and bubble masking of the payload.
  always_comb begin
    out_valid = vld_p0;
    in_ready  = (state_p0 != ST_SKID);
    occupancy = (state_p0 == ST_SKID) ? 2'd2 :
                (state_p0 == ST_FULL) ? 2'd1 : 2'd0;
    out_data  = vld_p0 ? main_p0 : {NUM_CH{BUBBLE}};
  end

  // Payload entries are never cleared: contents are don't-care while invalid.
  FlopEnRC #(.DATA_W(W)) u_main (
    .clk (clk),
    .en  (main_en),
    .clr (1'b0),
    .d   (main_d),
    .q   (main_p0)
  );

  FlopEnRC #(.DATA_W(W)) u_skid (
    .clk (clk),
    .en  (skid_en),
    .clr (1'b0),
    .d   (in_data),
    .q   (skid_p0)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and scoreboarded bench for pipe_skid_reg.
module tb_pipe_skid_reg;

  localparam int                DATA_W = 32;
  localparam int                NUM_CH = 2;
  localparam logic [DATA_W-1:0] BUB    = 32'hDEAD_BEEF;
  localparam logic [63:0]       BUB2   = {BUB, BUB};

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [63:0] in_data, out_data;
  logic [1:0]  occupancy;

  int checks = 0;
  int errors = 0;

  pipe_skid_reg #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .BUBBLE(BUB)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic v, input logic r,
                           input logic [1:0] occ, input logic [63:0] d);
    chk({tag, ".valid"}, {63'd0, out_valid}, {63'd0, v});
    chk({tag, ".ready"}, {63'd0, in_ready}, {63'd0, r});
    chk({tag, ".occ"}, {62'd0, occupancy}, {62'd0, occ});
    chk({tag, ".data"}, out_data, d);
  endtask

  function automatic logic [63:0] beat(input int k);
    return {32'h1000_0000 + k, 32'h2000_0000 + k};
  endfunction

  logic [63:0] sb[$];
  logic [63:0] exp_d;
  logic        do_push, do_pop;

  initial begin
    rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_data = '0;
    step();
    step();
    rst = 0;
    chk_state("reset", 1'b0, 1'b1, 2'd0, BUB2);

    // First beat: one-cycle latency into an empty stage
    in_valid = 1; out_ready = 1; in_data = {32'h2008_0005, 32'h0040_0000};
    step();
    chk_state("first", 1'b1, 1'b1, 2'd1, {32'h2008_0005, 32'h0040_0000});

    // Stream of 8 beats at full rate
    for (int k = 1; k <= 8; k++) begin
      in_data = beat(k);
      step();
      chk_state($sformatf("stream%0d", k), 1'b1, 1'b1, 2'd1, beat(k));
    end
    in_valid = 0;
    step();
    chk_state("drain", 1'b0, 1'b1, 2'd0, BUB2);

    // Stall: A into MAIN, B into SKID, then drain in order
    out_ready = 0; in_valid = 1; in_data = beat(20);
    step();
    chk_state("stallA", 1'b1, 1'b1, 2'd1, beat(20));
    in_data = beat(21);
    step();
    chk_state("stallB", 1'b1, 1'b0, 2'd2, beat(20));
    in_valid = 0; out_ready = 1;
    step();
    chk_state("popA", 1'b1, 1'b1, 2'd1, beat(21));
    step();
    chk_state("popB", 1'b0, 1'b1, 2'd0, BUB2);

    // Flush from SKID with in_valid high
    out_ready = 0; in_valid = 1; in_data = beat(30);
    step();
    in_data = beat(31);
    step();
    chk_state("preflush", 1'b1, 1'b0, 2'd2, beat(30));
    flush = 1; in_data = beat(32);
    step();
    chk_state("flushskid", 1'b0, 1'b1, 2'd0, BUB2);

    // Flush from FULL while a push is accepted: the pushed beat is dropped
    flush = 0; in_data = beat(33);
    step();
    chk_state("refill", 1'b1, 1'b1, 2'd1, beat(33));
    flush = 1; in_data = beat(34);
    step();
    chk_state("flushfull", 1'b0, 1'b1, 2'd0, BUB2);
    flush = 0; in_valid = 0;
    step();
    chk_state("postflush", 1'b0, 1'b1, 2'd0, BUB2);

    // rst together with flush while in SKID
    in_valid = 1; in_data = beat(40);
    step();
    in_data = beat(41);
    step();
    chk_state("prerst", 1'b1, 1'b0, 2'd2, beat(40));
    rst = 1; flush = 1; in_data = beat(42);
    step();
    chk_state("rstflush", 1'b0, 1'b1, 2'd0, BUB2);
    rst = 0; flush = 0; in_valid = 0;
    step();
    chk_state("postrst", 1'b0, 1'b1, 2'd0, BUB2);

    // Random handshakes against an ordered scoreboard
    for (int c = 0; c < 10000; c++) begin
      in_valid  = $urandom_range(0, 1);
      out_ready = $urandom_range(0, 1);
      in_data   = {$urandom, $urandom};
      #1;
      do_push = in_valid & in_ready;
      do_pop  = out_valid & out_ready;
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("rand.spurious", 64'd1, 64'd0);
        end else begin
          exp_d = sb[0];
          chk("rand.data", out_data, exp_d);
        end
      end
      if (do_pop && sb.size() != 0) void'(sb.pop_front());
      if (do_push) sb.push_back(in_data);
      step();
      chk("rand.occ", {62'd0, occupancy}, 64'(sb.size()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
